// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_DIV0_FLAG_EN: flag divide-by-zero on div0 and leave hi/lo untouched.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
`ifndef MULDIV_DIV0_FLAG_EN
  logic [WIDTH-1:0]   a_raw;
`endif

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] p_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic               idle_like;

  // prod holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    a_neg     = src_a[WIDTH-1] & ~op[0];
    b_neg     = src_b[WIDTH-1] & ~op[0];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd};
    div_diff  = div_shift[WIDTH-1:0] - opnd;
    p_fix     = neg_q ? -prod : prod;
    q_fix     = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    r_fix     = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    idle_like = (state == IDLE) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      prod   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0   <= 1'b0;
`else
      a_raw  <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      div0 <= 1'b0;
`endif
      if (idle_like && hi_we) hi <= wdata;
      if (idle_like && lo_we) lo <= wdata;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state  <= op[1] ? DIV : MUL;
              busy   <= 1'b1;
              cnt    <= '0;
              prod   <= {{WIDTH{1'b0}}, a_mag};
              opnd   <= b_mag;
              is_div <= op[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              b_zero <= (src_b == '0);
`ifndef MULDIV_DIV0_FLAG_EN
              a_raw  <= src_a;
`endif
            end else begin
              state <= IDLE;
            end
          end
          MUL: begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
          DIV: begin
            prod <= {(div_ge ? div_diff : div_shift[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
          FIX: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= p_fix;
            end else if (b_zero) begin
`ifdef MULDIV_DIV0_FLAG_EN
              div0 <= 1'b1;
`else
              hi   <= a_raw;
              lo   <= '1;
`endif
            end else begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifndef MULDIV_DIV0_FLAG_EN
  assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32); honours MULDIV_DIV0_FLAG_EN for the divide-by-zero case.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int unsigned  s;
    int unsigned  gap;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int unsigned last_done = 0;
  int          checks = 0;
  int          failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("res_hi", hi, e.hi);
        check("res_lo", lo, e.lo);
        check("res_div0", W'(div0), W'(e.div0));
        check("latency", W'(cyc - e.s), W'(W + 1));
        if (e.gap != 0) check("done_gap", W'(cyc - last_done), W'(e.gap));
      end
      last_done = cyc;
    end
  end

  // Called at a negedge; holds start until the DUT is not busy, returns at the negedge after acceptance
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input int unsigned gap, input bit push);
    int unsigned n = 0;
    op = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: busy still %0b, expected 0", busy);
    end
    if (push) exp_q.push_back('{eh, el, ed, cyc + 1, gap});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_div0", W'(div0), '0);
    rst_n = 1'b1;

    // first start right at reset release
    issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b1);
    wait_done();
`ifdef MULDIV_DIV0_FLAG_EN
    issue(2'b11, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 0, 1'b1);
`else
    issue(2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
`endif
    wait_done();
    check("div0_clear", W'(div0), '0);

    // back-to-back: second start held while busy, accepted in DONE
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0, 1'b1);
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34, 1'b1);
    wait_done();

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 1'b1);
    wait_done();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b1);
    wait_done();

    // MTHI / MTLO while idle
    hi_we = 1'b1; wdata = 32'hAAAA_0000;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hAAAA_0000);
    lo_we = 1'b1; wdata = 32'h0000_5555;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h0000_5555);

    // MTHI on the start edge lands, a write while busy is dropped, the result overwrites both
    hi_we = 1'b1; wdata = 32'h0000_CAFE;
    issue(2'b01, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0, 0, 1'b1);
    hi_we = 1'b0;
    check("mthi_with_start", hi, 32'h0000_CAFE);
    repeat (3) @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_busy_ignored", hi, 32'h0000_CAFE);
    wait_done();

    // flush at cycle 10 of a MULT
    issue(2'b00, 32'h0000_0002, 32'h0000_0003, '0, '0, 1'b0, 0, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", W'(busy), '0);
    check("flush_hi", hi, 32'h0000_0000);
    check("flush_lo", lo, 32'h0000_000C);
    repeat (40) @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_after_flush", hi, 32'h0000_1234);

    // flush together with MTLO while idle still writes
    flush = 1'b1; lo_we = 1'b1; wdata = 32'h0000_5A5A;
    @(negedge clk);
    flush = 1'b0; lo_we = 1'b0;
    check("flush_mtlo", lo, 32'h0000_5A5A);

    // reset at cycle 5 of a DIV
    issue(2'b10, 32'h0000_0064, 32'h0000_0007, '0, '0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, '0);
    check("midrst_lo", lo, '0);
    check("midrst_busy", W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // reset pulse, then a start presented at the first edge after release
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b01, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b0, 0, 1'b1);
    wait_done();

    check("queue_empty", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
